// File: rtl/bsg_mem_banked_init_pkg.sv
// Shared types and helpers for the banked, self-initialising 1RW memory.
package bsg_mem_banked_init_pkg;

   typedef enum logic {eInit, eReady} bsg_mem_init_state_e;

   // Address width that never collapses to zero bits for a depth of one.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit.sv
// Single-port synchronous memory with per-bit write mask and registered read data.
module bsg_mem_1rw_sync_mask_write_bit
   import bsg_mem_banked_init_pkg::*;
#(parameter int width_p           = 8
 ,parameter int els_p             = 8
 ,parameter int latch_last_read_p = 1
 ,parameter int addr_width_lp     = safe_clog2(els_p)
)
(input  logic                     clk_i
,input  logic                     v_i
,input  logic                     w_i
,input  logic [addr_width_lp-1:0] addr_i
,input  logic [width_p-1:0]       data_i
,input  logic [width_p-1:0]       w_mask_i
,output logic [width_p-1:0]       data_o
);

   logic [width_p-1:0] mem_r [els_p];
   logic [width_p-1:0] data_r;

   always_ff @(posedge clk_i)
      if (v_i & w_i)
         mem_r[addr_i] <= (mem_r[addr_i] & ~w_mask_i) | (data_i & w_mask_i);

   // Without latching, the read register is free to follow any access.
   if (latch_last_read_p != 0) begin : latch
      always_ff @(posedge clk_i)
         if (v_i & ~w_i) data_r <= mem_r[addr_i];
   end else begin : nolatch
      always_ff @(posedge clk_i)
         if (v_i) data_r <= mem_r[addr_i];
   end

   assign data_o = data_r;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init.sv
// Depth-banked 1RW bit-mask memory with a sweep engine that fills every word
// with init_val_p after reset or on clear_i; ready_o gates client access.
module bsg_mem_1rw_sync_mask_write_bit_banked_init
   import bsg_mem_banked_init_pkg::*;
#(parameter int width_p           = 8
 ,parameter int els_p             = 16
 ,parameter int num_banks_p       = 2
 ,parameter int latch_last_read_p = 1
 ,parameter int init_on_reset_p   = 1
 ,parameter logic [width_p-1:0] init_val_p = '0
 ,parameter int addr_width_lp      = safe_clog2(els_p)
 ,parameter int bank_els_lp        = els_p / num_banks_p
 ,parameter int bank_addr_width_lp = safe_clog2(bank_els_lp)
 ,parameter int bank_sel_width_lp  = safe_clog2(num_banks_p)
)
(input  logic                     clk_i
,input  logic                     reset_i
,input  logic                     v_i
,input  logic                     w_i
,input  logic [addr_width_lp-1:0] addr_i
,input  logic [width_p-1:0]       data_i
,input  logic [width_p-1:0]       w_mask_i
,input  logic                     clear_i
,output logic                     ready_o
,output logic [width_p-1:0]       data_o
);

   localparam logic [bank_addr_width_lp:0] cnt_last_lp = (bank_addr_width_lp+1)'(bank_els_lp-1);
   localparam bsg_mem_init_state_e reset_state_lp = (init_on_reset_p != 0) ? eInit : eReady;

   bsg_mem_init_state_e state_r, state_n;
   logic [bank_addr_width_lp:0] cnt_r, cnt_n;
   logic [bank_sel_width_lp-1:0] bank_sel, rd_bank_r;
   logic [bank_addr_width_lp-1:0] row, bank_addr;
   logic [width_p-1:0] bank_data, bank_mask;
   logic sweep, access, bank_w;
   logic [num_banks_p-1:0] bank_v;
   logic [num_banks_p-1:0][width_p-1:0] bank_data_lo;

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_r   <= reset_state_lp;
         cnt_r     <= '0;
         rd_bank_r <= '0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         if (access & ~w_i) rd_bank_r <= bank_sel;
      end

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      ready_o = 1'b0;
      case (state_r)
         eInit: begin
            cnt_n = cnt_r + 1'b1;
            if (cnt_r == cnt_last_lp) begin
               state_n = eReady;
               cnt_n   = '0;
            end
         end
         eReady: begin
            ready_o = 1'b1;
            // An access in the same cycle as clear_i still completes.
            if (clear_i) begin
               state_n = eInit;
               cnt_n   = '0;
            end
         end
         default: state_n = reset_state_lp;
      endcase
   end

   assign sweep  = (state_r == eInit);
   assign access = v_i & ready_o;
   assign row    = addr_i[bank_addr_width_lp-1:0];

   if (num_banks_p > 1) begin : sel
      assign bank_sel = addr_i[addr_width_lp-1 -: bank_sel_width_lp];
      assign data_o   = bank_data_lo[rd_bank_r];
   end else begin : nosel
      assign bank_sel = '0;
      assign data_o   = bank_data_lo[0];
   end

   // During the sweep every bank writes the same row in parallel.
   assign bank_addr = sweep ? cnt_r[bank_addr_width_lp-1:0] : row;
   assign bank_data = sweep ? init_val_p : data_i;
   assign bank_mask = sweep ? {width_p{1'b1}} : w_mask_i;
   assign bank_w    = sweep | w_i;

   for (genvar b = 0; b < num_banks_p; b++) begin : bank
      assign bank_v[b] = sweep | (access & (bank_sel == bank_sel_width_lp'(b)));

      bsg_mem_1rw_sync_mask_write_bit #(
         .width_p(width_p)
        ,.els_p(bank_els_lp)
        ,.latch_last_read_p(latch_last_read_p)
      ) mem (
         .clk_i(clk_i)
        ,.v_i(bank_v[b])
        ,.w_i(bank_w)
        ,.addr_i(bank_addr)
        ,.data_i(bank_data)
        ,.w_mask_i(bank_mask)
        ,.data_o(bank_data_lo[b])
      );
   end

   addr_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
      access |-> (32'(addr_i) < els_p));

endmodule
